// File: rtl/seq_adder_pkg.sv
// ----------------------------------------------------------------------------
// seq_adder_pkg
//   Shared definitions for the sequential chunked adder:
//     state_t    - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//     idx_width  - width of the chunk index counter, clog2 with a floor of 1
// ----------------------------------------------------------------------------
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk build still needs a 1-bit index so the counter exists.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/AdderNBit.sv
// ----------------------------------------------------------------------------
// AdderNBit
//   Combinational N-bit ripple-carry adder used as the per-chunk datapath.
//   Ports:
//     a, b   in  N  addends
//     c_in   in  1  carry into bit 0
//     sum    out N  (a + b + c_in) mod 2^N
//     c_out  out 1  carry out of bit N-1
// ----------------------------------------------------------------------------
module AdderNBit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    always_comb begin
        logic c;
        // NOTE: every output gets a default before the loop so no path can
        // leave a bit unassigned and infer a latch.
        sum = '0;
        c   = c_in;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// ----------------------------------------------------------------------------
// seq_chunk_adder
//   W = N*CHUNKS bit adder built from one N-bit ripple adder, processing one
//   chunk per clock LSB-first and keeping the inter-chunk carry in a register.
//   Operands are taken on a valid/ready handshake and the result is returned
//   on a second valid/ready handshake.
//   Ports:
//     clk        in   1  clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     in_valid   in   1  a, b, c_in are valid
//     in_ready   out  1  operands can be accepted (IDLE only)
//     a, b       in   W  operands
//     c_in       in   1  carry into bit 0
//     out_valid  out  1  sum/c_out valid (DONE only)
//     out_ready  in   1  consumer takes the result
//     sum        out  W  (a + b + c_in) mod 2^W
//     c_out      out  1  bit W of a + b + c_in
// ----------------------------------------------------------------------------
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int N      = 4,
    parameter int CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*CHUNKS-1:0]   a,
    input  logic [N*CHUNKS-1:0]   b,
    input  logic                  c_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*CHUNKS-1:0]   sum,
    output logic                  c_out
);

    localparam int             IW       = idx_width(CHUNKS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(CHUNKS - 1);

    state_t                     state;
    logic [IW-1:0]              idx;
    logic                       carry;
    logic [CHUNKS-1:0][N-1:0]   a_q;
    logic [CHUNKS-1:0][N-1:0]   b_q;
    logic [CHUNKS-1:0][N-1:0]   sum_q;

    logic [N-1:0]               chunk_sum;
    logic                       chunk_cout;

    AdderNBit #(.N(N)) u_adder (
        .a     (a_q[idx]),
        .b     (b_q[idx]),
        .c_in  (carry),
        .sum   (chunk_sum),
        .c_out (chunk_cout)
    );

    assign sum = sum_q;

    // in_ready/out_valid are registered alongside the state so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand registers are plain flops, not a memory, so
            // resetting them costs nothing and keeps post-reset state defined.
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            c_out     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= c_in;
                        idx      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx] <= chunk_sum;
                    carry      <= chunk_cout;
                    idx        <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        c_out     <= chunk_cout;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // sum/c_out are left untouched here so they stay held
                    // until the next operation overwrites them.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
